// File: rtl/ili_init_seq.sv
// ili_init_seq: ILI9341 power-up sequencer.
// Drives the panel hardware reset pulse, then walks a command/data table held
// in an external synchronous ROM and hands each byte to the SPI byte shifter.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          begin sequence (IDLE only) / cancel sequence
//   cmd_len               number of table entries, latched on accepted start
//   rom_addr, rom_data    table index out, entry in one cycle later
//                         ({delay flag, dc, byte-or-count})
//   tx_data, tx_dc        byte and D/C offered to the shifter
//   tx_valid, tx_ready    byte handshake
//   tx_sent               shifter finished the byte (1-cycle pulse)
//   cs, lcd_reset         panel chip select and reset, both active low
//   busy, done, init_ok   status: not idle / completion pulse / sticky success
module ili_init_seq #(
  parameter int unsigned DW           = 8,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned RST_HI_CYC   = 16,
  parameter int unsigned RST_LO_CYC   = 16,
  parameter int unsigned RST_WAIT_CYC = 32,
  parameter int unsigned GAP_CYC      = 8,
  parameter int unsigned CS_HOLD_CYC  = 2,
  parameter int unsigned DLY_UNIT     = 1024,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   cmd_len,
  output logic [AW-1:0] rom_addr,
  input  logic [DW+1:0] rom_data,
  output logic [DW-1:0] tx_data,
  output logic          tx_dc,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic          tx_sent,
  output logic          cs,
  output logic          lcd_reset,
  output logic          busy,
  output logic          done,
  output logic          init_ok
);

  localparam int unsigned IW      = AW + 1;
  localparam int unsigned DLY_MAX = DLY_UNIT * ((2 ** DW) - 1);
  localparam int unsigned DCW     = $clog2(DLY_MAX + 1);
  localparam int unsigned T_A     = (RST_HI_CYC > RST_LO_CYC) ? RST_HI_CYC : RST_LO_CYC;
  localparam int unsigned T_B     = (RST_WAIT_CYC > GAP_CYC) ? RST_WAIT_CYC : GAP_CYC;
  localparam int unsigned T_C     = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned T_MAX   = (T_C > CS_HOLD_CYC) ? T_C : CS_HOLD_CYC;
  localparam int unsigned TCW     = $clog2(T_MAX + 1);
  // One down-counter serves the reset phases, gaps, hold and delay entries.
  localparam int unsigned CW      = (DCW > TCW) ? DCW : TCW;

  typedef enum logic [3:0] {
    S_IDLE, S_RST_HI, S_RST_LO, S_RST_WAIT, S_FETCH, S_DECODE, S_SEND,
    S_WAIT_SENT, S_DELAY, S_ADVANCE, S_GAP, S_CS_HOLD, S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] len_q;

  // Sequencer: state, counters and registered outputs move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      len_q     <= '0;
      rom_addr  <= '0;
      tx_data   <= '0;
      tx_dc     <= 1'b1;
      tx_valid  <= 1'b0;
      cs        <= 1'b1;
      lcd_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      init_ok   <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      // Cancel: back to idle outputs, init_ok left alone.
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      rom_addr  <= '0;
      tx_data   <= '0;
      tx_dc     <= 1'b1;
      tx_valid  <= 1'b0;
      cs        <= 1'b1;
      lcd_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RST_HI;
            busy     <= 1'b1;
            init_ok  <= 1'b0;
            len_q    <= (cmd_len > IW'(DEPTH)) ? IW'(DEPTH) : cmd_len;
            idx      <= '0;
            rom_addr <= '0;
            cnt      <= CW'(RST_HI_CYC - 1);
          end
        end
        S_RST_HI: begin
          if (cnt == '0) begin
            state     <= S_RST_LO;
            lcd_reset <= 1'b0;
            cnt       <= CW'(RST_LO_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RST_LO: begin
          if (cnt == '0) begin
            state     <= S_RST_WAIT;
            lcd_reset <= 1'b1;
            cnt       <= CW'(RST_WAIT_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RST_WAIT: begin
          if (cnt == '0) begin
            if (len_q == '0) begin
              // Empty table: finish without ever selecting the panel.
              state   <= S_DONE;
              done    <= 1'b1;
              init_ok <= 1'b1;
            end else begin
              state <= S_FETCH;
              cs    <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (rom_data[DW+1]) begin
            if (rom_data[DW-1:0] != '0) begin
              state <= S_DELAY;
              cnt   <= CW'(rom_data[DW-1:0]) * CW'(DLY_UNIT) - CW'(1);
            end else begin
              state <= S_ADVANCE;
            end
          end else begin
            state    <= S_SEND;
            tx_data  <= rom_data[DW-1:0];
            tx_dc    <= rom_data[DW];
            tx_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            state    <= S_WAIT_SENT;
            tx_valid <= 1'b0;
          end
        end
        S_WAIT_SENT: begin
          if (tx_sent) state <= S_ADVANCE;
        end
        S_DELAY: begin
          if (cnt == '0) state <= S_ADVANCE;
          else           cnt   <= cnt - CW'(1);
        end
        S_ADVANCE: begin
          idx      <= idx + IW'(1);
          rom_addr <= AW'(idx + IW'(1));
          if ((idx + IW'(1)) == len_q) begin
            state <= S_CS_HOLD;
            cnt   <= CW'(CS_HOLD_CYC - 1);
          end else begin
            state <= S_GAP;
            cnt   <= CW'(GAP_CYC - 1);
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_FETCH;
          else           cnt   <= cnt - CW'(1);
        end
        S_CS_HOLD: begin
          if (cnt == '0) begin
            state   <= S_DONE;
            cs      <= 1'b1;
            done    <= 1'b1;
            init_ok <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ili_init_seq.sv
// tb_ili_init_seq: self-checking bench for ili_init_seq.
// A shifter model answers the byte handshake with per-byte stall/latency,
// a monitor tallies pin activity, and each run is compared against a
// table-walk model computed from the entry list and timing parameters.
module tb_ili_init_seq;

  localparam int DW = 8, DEPTH = 8, AW = 3;
  localparam int RHI = 2, RLO = 3, RWAIT = 4, GAP = 2, HOLD = 2, DLY = 4;

  logic          clk, rst, start, abort;
  logic [AW:0]   cmd_len;
  logic [AW-1:0] rom_addr;
  logic [DW+1:0] rom_data;
  logic [DW-1:0] tx_data;
  logic          tx_dc, tx_valid, tx_ready, tx_sent;
  logic          cs, lcd_reset, busy, done, init_ok;

  ili_init_seq #(
    .DW(DW), .DEPTH(DEPTH), .RST_HI_CYC(RHI), .RST_LO_CYC(RLO),
    .RST_WAIT_CYC(RWAIT), .GAP_CYC(GAP), .CS_HOLD_CYC(HOLD), .DLY_UNIT(DLY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cmd_len(cmd_len),
    .rom_addr(rom_addr), .rom_data(rom_data), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sent(tx_sent), .cs(cs),
    .lcd_reset(lcd_reset), .busy(busy), .done(done), .init_ok(init_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous table ROM.
  logic [DW+1:0] rom [DEPTH];
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0, bad = 0;

  // Per-byte shifter behaviour, pushed by the main sequence.
  int          stall_q[$], lat_q[$];
  bit          stray_q[$];
  logic [8:0]  got_q[$];
  int          stray_cnt = 0, stray_done = 0;

  // Monitor tallies (cumulative; the main sequence takes deltas).
  int cyc = 0, lcd_low_n = 0, lcd_fall_cyc = 0, cs_low_n = 0, cs_fall_n = 0;
  int done_n = 0, done_cyc = 0, valid_n = 0, unstable_n = 0;
  bit prev_lcd = 1'b1, prev_cs = 1'b1, prev_valid = 1'b0;
  logic [8:0] prev_byte = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({cs, lcd_reset, tx_valid, tx_data, tx_dc, rom_addr, busy, done, init_ok});
  endfunction

  // Monitor: samples just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (lcd_reset === 1'b0) begin
        lcd_low_n++;
        if (prev_lcd) lcd_fall_cyc = cyc;
      end
      if (cs === 1'b0) begin
        cs_low_n++;
        if (prev_cs) cs_fall_n++;
      end
      if (done === 1'b1) begin
        done_n++;
        done_cyc = cyc;
      end
      if (tx_valid === 1'b1) valid_n++;
      // tx_ready here is still the value the DUT sampled at this edge.
      if (prev_valid && (tx_ready !== 1'b1) &&
          ((tx_valid !== 1'b1) || ({tx_dc, tx_data} !== prev_byte)))
        unstable_n++;
      prev_lcd   = (lcd_reset !== 1'b0);
      prev_cs    = (cs !== 1'b0);
      prev_valid = (tx_valid === 1'b1);
      prev_byte  = {tx_dc, tx_data};
    end
  end

  // Shifter model: stall k cycles, accept, then pulse tx_sent L cycles later.
  initial begin
    int st, c, nacc, k, l;
    st = 0; c = 0; nacc = 0;
    tx_ready = 1'b0;
    tx_sent  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_sent = 1'b0;
      if (stray_done != stray_cnt) begin
        tx_sent = 1'b1;
        stray_done++;
      end
      case (st)
        0: if (tx_valid === 1'b1) begin
          k = (nacc < stall_q.size()) ? stall_q[nacc] : 0;
          if ((nacc < stray_q.size()) && stray_q[nacc] && (k > 0)) tx_sent = 1'b1;
          if (k == 0) begin
            tx_ready = 1'b1;
            got_q.push_back({tx_dc, tx_data});
            st = 2;
          end else begin
            c  = k - 1;
            st = 1;
          end
        end
        1: begin
          if (c == 0) begin
            tx_ready = 1'b1;
            got_q.push_back({tx_dc, tx_data});
            st = 2;
          end else begin
            c--;
          end
        end
        2: begin
          tx_ready = 1'b0;
          l = (nacc < lat_q.size()) ? lat_q[nacc] : 1;
          nacc++;
          if (l <= 1) begin
            tx_sent = 1'b1;
            st = 0;
          end else begin
            c  = l - 2;
            st = 3;
          end
        end
        default: begin
          if (c == 0) begin
            tx_sent = 1'b1;
            st = 0;
          end else begin
            c--;
          end
        end
      endcase
    end
  end

  // One full sequence: model the expected trace from the table, run, compare.
  task automatic run_seq(input int len_in, input int fstall, input int flat,
                         input bit stray, input bit with_abort);
    int n, t_exp, cs_exp, v_exp, base, d0, ll0, cl0, cf0, v0, u0, s, soff;
    logic [8:0] exp_q[$];
    bit seen;
    n = (len_in > DEPTH) ? DEPTH : len_in;
    t_exp = 1 + RHI + RLO + RWAIT;
    v_exp = 0;
    for (int i = 0; i < n; i++) begin
      logic [9:0] e;
      int stl, lt, body;
      e = rom[i];
      if (e[9]) begin
        body = int'(e[7:0]) * DLY;
      end else begin
        stl = (fstall < 0) ? int'($urandom_range(0, 6)) : fstall;
        lt  = (flat < 0) ? int'($urandom_range(1, 6)) : flat;
        stall_q.push_back(stl);
        lat_q.push_back(lt);
        stray_q.push_back(stray);
        exp_q.push_back(e[8:0]);
        body  = stl + 1 + lt;
        v_exp += stl + 1;
      end
      t_exp += 3 + body;
    end
    if (n > 0) t_exp += (n - 1) * GAP + HOLD;
    cs_exp = (n > 0) ? t_exp - (1 + RHI + RLO + RWAIT) : 0;

    base = got_q.size(); d0 = done_n; ll0 = lcd_low_n; cl0 = cs_low_n;
    cf0 = cs_fall_n; v0 = valid_n; u0 = unstable_n;
    soff = int'($urandom_range(2, t_exp - 1));
    cmd_len = 4'(len_in);
    start = 1'b1;
    abort = with_abort;
    s = cyc;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    seen = 1'b0;
    for (int k = 1; k < t_exp + 40; k++) begin
      if (done_n != d0) begin
        seen = 1'b1;
        break;
      end
      start = stray && (k == soff);
      tick(1);
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("done_at", 32'(done_cyc - s), 32'(t_exp));
    check("lcd_fall_at", 32'(lcd_fall_cyc - s), 32'(1 + RHI));
    check("lcd_low_cyc", 32'(lcd_low_n - ll0), 32'(RLO));
    check("cs_low_cyc", 32'(cs_low_n - cl0), 32'(cs_exp));
    check("cs_runs", 32'(cs_fall_n - cf0), 32'((n > 0) ? 1 : 0));
    check("valid_cyc", 32'(valid_n - v0), 32'(v_exp));
    check("valid_stable", 32'(unstable_n - u0), 32'd0);
    check("byte_count", 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        check($sformatf("byte%0d", i), 32'(got_q[base + i]), 32'(exp_q[i]));
    tick(3);
    check("done_once", 32'(done_n - d0), 32'd1);
    check("idle_status", 32'({busy, cs, init_ok}), 32'(3'b011));
  endtask

  initial begin
    int s, d0;
    logic [17:0] rv, rv_abort;
    rv       = {1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    rv_abort = rv;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_len = '0;
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    tick(3);
    check("reset_outs", outs(), 32'(rv));
    rst = 1'b0;
    tick(2);

    // Empty table: reset pulse only, cs never asserted.
    run_seq(0, 0, 1, 1'b0, 1'b0);

    // Command, 2-unit delay, data byte.
    rom[0] = 10'h011; rom[1] = 10'h202; rom[2] = 10'h1A5;
    run_seq(3, 0, 5, 1'b0, 1'b0);

    // Six stall cycles with a stray tx_sent while the byte is still offered.
    rom[0] = 10'h05A;
    run_seq(1, 6, 3, 1'b1, 1'b0);

    // Zero-count delay entry plus stray start/tx_sent pulses.
    rom[0] = 10'h200; rom[1] = 10'h0AB; rom[2] = 10'h136;
    run_seq(3, -1, -1, 1'b1, 1'b0);

    // Abort in the middle of a delay entry.
    rom[0] = 10'h203; rom[1] = 10'h011; cmd_len = 4'd2;
    d0 = done_n;
    start = 1'b1; s = cyc; tick(1); start = 1'b0;
    tick(13);
    check("pre_abort", 32'({cs, busy, tx_valid}), 32'(3'b010));
    abort = 1'b1; tick(1); abort = 1'b0;
    check("abort_outs", outs(), 32'(rv_abort));
    stray_cnt++;
    tick(20);
    check("abort_stays_idle", 32'({busy, cs}), 32'(2'b01));
    check("abort_no_done", 32'(done_n - d0), 32'd0);

    // Reset while waiting for tx_sent, then a full rerun (start+abort in IDLE).
    rom[0] = 10'h02C; rom[1] = 10'h1C3; cmd_len = 4'd2;
    stall_q.push_back(0); lat_q.push_back(30); stray_q.push_back(1'b0);
    d0 = done_n;
    start = 1'b1; s = cyc; tick(1); start = 1'b0;
    tick(15);
    check("pre_rst", 32'({busy, tx_valid, cs}), 32'(3'b100));
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst_outs", outs(), 32'(rv));
    tick(40);
    check("rst_no_done", 32'(done_n - d0), 32'd0);
    run_seq(2, -1, -1, 1'b0, 1'b1);

    // Random tables and lengths, including lengths beyond DEPTH.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [9:0] e;
        e = 10'($urandom);
        if (e[9]) e[7:0] = 8'($urandom_range(0, 3));
        rom[i] = e;
      end
      run_seq(int'($urandom_range(0, 12)), -1, -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
